operand_capture: RTL

//  Upstream input stage for the ALU board top level. Synchronises and debounces the four

---
 rtl/operand_capture_pkg.sv | 33 +++
 rtl/operand_capture_key_debouncer.sv | 96 +++++++++
 rtl/operand_capture.sv | 131 +++++++++++++
 3 files changed

// File: rtl/operand_capture_pkg.sv
// Shared definitions for the operand capture stage: display-source codes,
// debounce FSM states and key roles.
package operand_capture_pkg;

    // Display source select codes driven on oShowSel
    localparam logic [1:0] SHOW_RESULT = 2'b00;
    localparam logic [1:0] SHOW_A      = 2'b01;
    localparam logic [1:0] SHOW_B      = 2'b10;

    // Number of push-buttons and the role each one plays
    localparam int NUM_KEYS   = 4;
    localparam int KEY_LOAD_A = 0;
    localparam int KEY_LOAD_B = 1;
    localparam int KEY_SHOW_A = 2;
    localparam int KEY_SHOW_B = 3;

    // Per-key debounce FSM states
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } deb_state_e;

    // Width of a counter that must hold values 0..max_val (at least 1 bit)
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : operand_capture_pkg

// File: rtl/operand_capture_key_debouncer.sv
// key_debouncer: two-flop synchroniser, debounce FSM and stability counter for
// one active-low push-button. oLevel is the accepted (debounced) key level,
// oFall is a registered one-cycle pulse on each accepted 1->0 transition.
module key_debouncer
    import operand_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iRaw,
    output logic oLevel,
    output logic oFall
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so it never wraps
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             fall_q;
    logic             fall_d;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= iRaw;
            sync2_q <= sync1_q;
        end
    end

    // FSM state, counter, accepted level and press-pulse registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: a new level is accepted only after it has differed
    // from the current level for DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_COUNT: begin
                if (sync2_q == level_q) begin
                    // bounced back before the window elapsed
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = sync2_q;
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        // press = accepted level going from released to pressed
        fall_d = level_q & ~level_d;
    end

    assign oLevel = level_q;
    assign oFall  = fall_q;

endmodule : key_debouncer

// File: rtl/operand_capture.sv
// operand_capture: input stage for the ALU board. Debounces the four keys,
// synchronises the slide switches, captures sign-extended operands A/B on
// clean KEY[0]/KEY[1] presses and selects the display source from KEY[2]/KEY[3].
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 10,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [NUM_KEYS-1:0]   iKEY,
    input  logic [SW_WIDTH-1:0]   iSW,
    output logic [DATA_WIDTH-1:0] oA,
    output logic [DATA_WIDTH-1:0] oB,
    output logic                  oLoadA,
    output logic                  oLoadB,
    output logic [1:0]            oShowSel,
    output logic                  oValid
);

    logic [SW_WIDTH-1:0]   sw_sync1_q;
    logic [SW_WIDTH-1:0]   sw_sync2_q;
    logic [DATA_WIDTH-1:0] sw_ext;
    logic [NUM_KEYS-1:0]   key_level;
    logic [NUM_KEYS-1:0]   key_fall;

    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] a_d;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] b_d;
    logic                  load_a_q;
    logic                  load_a_d;
    logic                  load_b_q;
    logic                  load_b_d;
    logic                  seen_a_q;
    logic                  seen_a_d;
    logic                  seen_b_q;
    logic                  seen_b_d;
    logic                  valid_q;
    logic                  valid_d;
    logic [1:0]            show_sel;

    // One independent debouncer per key
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi = gi + 1) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .iCLK  (iCLK),
                .iRST  (iRST),
                .iRaw  (iKEY[gi]),
                .oLevel(key_level[gi]),
                .oFall (key_fall[gi])
            );
        end
    endgenerate

    // Switch bus synchroniser; bus skew is harmless since switches settle
    // long before a key press is accepted
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
        end else begin
            sw_sync1_q <= iSW;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    assign sw_ext = {{(DATA_WIDTH - SW_WIDTH){sw_sync2_q[SW_WIDTH-1]}}, sw_sync2_q};

    // Operand capture, load pulses and the both-loaded flag
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        load_a_d = key_fall[KEY_LOAD_A];
        load_b_d = key_fall[KEY_LOAD_B];
        if (key_fall[KEY_LOAD_A]) begin
            a_d = sw_ext;
        end
        if (key_fall[KEY_LOAD_B]) begin
            b_d = sw_ext;
        end
        seen_a_d = seen_a_q | key_fall[KEY_LOAD_A];
        seen_b_d = seen_b_q | key_fall[KEY_LOAD_B];
        valid_d  = valid_q | (seen_a_d & seen_b_d);
    end

    // Operand registers; cleared only by reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            a_q      <= '0;
            b_q      <= '0;
            load_a_q <= 1'b0;
            load_b_q <= 1'b0;
            seen_a_q <= 1'b0;
            seen_b_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            load_a_q <= load_a_d;
            load_b_q <= load_b_d;
            seen_a_q <= seen_a_d;
            seen_b_q <= seen_b_d;
            valid_q  <= valid_d;
        end
    end

    // Display source from debounced levels only, so bounce never shows through;
    // KEY[2] has priority over KEY[3]
    always_comb begin
        show_sel = SHOW_RESULT;
        if (!key_level[KEY_SHOW_A]) begin
            show_sel = SHOW_A;
        end else if (!key_level[KEY_SHOW_B]) begin
            show_sel = SHOW_B;
        end
    end

    assign oA       = a_q;
    assign oB       = b_q;
    assign oLoadA   = load_a_q;
    assign oLoadB   = load_b_q;
    assign oShowSel = show_sel;
    assign oValid   = valid_q;

endmodule : operand_capture
